mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
// Memory-side responder for the CPU's byte-serial memory port: byte-addressed RAM plus a memory-mapped I/O window.
// Accepts one byte read or write per cycle on mem_a/mem_wr/mem_dout.
// Returns read bytes on mem_din with 1-cycle latency. Buffers I/O output bytes in a TX FIFO.
// Drives io_buffer_full back to the memory controller, which stalls while it is high.
// PARAMETERS
// RAM_AW      17        RAM address bits; RAM holds 2**RAM_AW bytes, indexed by mem_a[RAM_AW-1:0]
// IO_SEL      2'b11     value of mem_a[17:16] that selects the I/O window
// FIFO_AW     3         TX FIFO depth = 2**FIFO_AW = 8 entries
// FULL_SLACK  2         io_buffer_full asserts when fifo_count >= depth - FULL_SLACK
// PORTS
// clk          in   1   clock
// rst          in   1   reset, asynchronous, active-high
// rdy          in   1   global enable; when 0, RAM/FIFO/rx state and mem_din hold
// mem_a        in   32  byte address from memory controller
// mem_wr       in   1   1 = write mem_dout at mem_a this cycle, 0 = read
// mem_dout     in   8   write data from controller
// mem_din      out  8   read data, valid the cycle after the address
// io_buffer_full out 1  registered; TX FIFO near full, controller must stall
// tx_data      out  8   FIFO head byte to the UART/host sink
// tx_valid     out  1   FIFO non-empty
// tx_ready     in   1   sink accepts head byte when tx_valid & tx_ready at posedge
// rx_data      in   8   input byte from host
// rx_valid     in   1   rx_data holds an unread byte
// rx_pop       out  1   1-cycle pulse: rx byte consumed
// tx_overflow  out  1   sticky; a write hit a full FIFO and was dropped
// BEHAVIOUR
// - Reset (async): mem_din=0, io_buffer_full=0, tx_valid=0, rx_pop=0, tx_overflow=0, FIFO pointers/count=0. RAM contents are not reset.
// - Decode: io = (mem_a[17:16]==IO_SEL). Everything else goes to RAM, wrapping modulo 2**RAM_AW.
// - RAM read: mem_a sampled at posedge N; mem_din = ram[a] during cycle N+1.
//   Read-first: a read and a write to the same address in the same cycle cannot occur (single port).
//   A read at N+1 of a byte written at N returns the new data.
// - RAM write (mem_wr=1, !io): ram[a] <= mem_dout at posedge. mem_din is 0 the following cycle.
// - I/O write to offset 0x0 (a[2:0]==0): push mem_dout into the TX FIFO.
//   If the FIFO is full: byte dropped, tx_overflow<=1. Writes to other I/O offsets are ignored.
// - I/O read, offset 0x0: mem_din = rx_data if rx_valid, else 8'h00. rx_pop pulses for 1 cycle when rx_valid.
// - I/O read, offset 0x4: mem_din = {6'b0, tx_empty, rx_valid}. No side effects.
// - I/O read, other offsets: mem_din = 0.
// - FIFO: pop when tx_valid & tx_ready. Push and pop in the same cycle leave the count unchanged.
//   A push onto a full FIFO with a simultaneous pop is accepted (no overflow). Pointers wrap mod depth.
// - io_buffer_full <= (next_count >= depth-FULL_SLACK), registered. The slack absorbs in-flight store bytes,
//   since the controller sees the flag one cycle late. Deasserts as soon as the count drops below the threshold.
// - rdy=0: no push, no RAM write, no rx_pop. tx pop is still honoured so the sink can drain.
// - Reset mid-burst: all in-flight state is dropped; the FIFO empties. The RAM write of that same edge is not performed.
// STRUCTURE
// - Shared package/config: IO_SEL, IO offset constants (IO_DATA=3'h0, IO_STAT=3'h4), status bit positions.
// - Sub-module io_tx_fifo (sync FIFO, count output, push/pop/full/empty) instantiated once.
// - Top level holds the RAM array, address decode, mem_din register, rx_pop, overflow and full logic.
// TESTING
// - Write 0xAB to 0x00010, read 0x00010 next cycle -> mem_din=0xAB one cycle after the read address.
// - Write 4 bytes 0x11..0x44 to 0x00100..0x00103, read them back -> mem_din 0x11,0x22,0x33,0x44 on consecutive cycles.
// - tx_ready=0, 6 I/O writes to 0x30000 -> io_buffer_full=1 the cycle after the 6th push;
//   2 more writes fill the FIFO, a 9th sets tx_overflow=1 with count held at 8.
// - FIFO full, tx_ready=1 with a simultaneous I/O write -> count stays 8, no overflow; head order preserved.
// - rx_valid=1, rx_data=0x5A, read 0x30000 -> mem_din=0x5A, rx_pop single pulse; read 0x30004 -> bit0=rx_valid.
// - Assert rst mid-stream with 5 FIFO entries -> tx_valid=0, io_buffer_full=0 immediately; RAM data written before reset still reads back.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared decode constants, request bundle and status-byte packing for the
// memory-side responder.
package mem_io_responder_pkg;

  localparam logic [1:0] IO_SEL_DEF    = 2'b11;
  localparam logic [2:0] IO_DATA       = 3'h0;
  localparam logic [2:0] IO_STAT       = 3'h4;
  localparam int         STAT_RX_VALID = 0;
  localparam int         STAT_TX_EMPTY = 1;

  typedef struct packed {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } mem_req_t;

  function automatic logic [7:0] stat_byte(input logic tx_empty, input logic rx_valid);
    logic [7:0] s;
    s                = '0;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_RX_VALID] = rx_valid;
    return s;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous TX FIFO. A push onto a full FIFO is accepted only when a pop
// frees a slot on the same edge.
module io_tx_fifo #(
  parameter int AW = 3,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [AW:0]   next_count
);

  localparam int DEPTH = 2**AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_comb begin
    next_count = count;
    if (do_push && !do_pop)      next_count = count + 1'b1;
    else if (!do_push && do_pop) next_count = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= next_count;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-serial memory responder: RAM plus an I/O window with a TX FIFO,
// rx byte reads and a status register. Read data has one cycle of latency.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int         RAM_AW     = 17,
  parameter logic [1:0] IO_SEL     = IO_SEL_DEF,
  parameter int         FIFO_AW    = 3,
  parameter int         FULL_SLACK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        tx_overflow
);

  localparam int               DEPTH    = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_THR = (FIFO_AW+1)'(DEPTH - FULL_SLACK);

  mem_req_t          req;
  logic [7:0]        ram [2**RAM_AW];
  logic              io;
  logic [2:0]        off;
  logic [RAM_AW-1:0] ram_a;
  logic              push_req, pop_req;
  logic              fifo_full, fifo_empty;
  logic [FIFO_AW:0]  fifo_count, fifo_next;
  logic [7:0]        rd_next;
  logic              unused_bits;

  assign req         = '{a: mem_a, wr: mem_wr, d: mem_dout};
  assign io          = (req.a[17:16] == IO_SEL);
  assign off         = req.a[2:0];
  assign ram_a       = req.a[RAM_AW-1:0];
  assign push_req    = rdy & io & req.wr & (off == IO_DATA);
  assign pop_req     = tx_valid & tx_ready;
  assign tx_valid    = ~fifo_empty;
  assign unused_bits = ^{req.a[31:18], fifo_count};

  io_tx_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_req),
    .pop        (pop_req),
    .din        (req.d),
    .dout       (tx_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .next_count (fifo_next)
  );

  // Writes of either kind return zero on the following cycle.
  always_comb begin
    rd_next = '0;
    if (!req.wr) begin
      if (io) begin
        case (off)
          IO_DATA: rd_next = rx_valid ? rx_data : 8'h00;
          IO_STAT: rd_next = stat_byte(fifo_empty, rx_valid);
          default: rd_next = '0;
        endcase
      end else begin
        rd_next = ram[ram_a];
      end
    end
  end

  // The full flag tracks the post-edge count even when rdy is low, since the
  // sink may still be draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_din        <= '0;
      rx_pop         <= 1'b0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      io_buffer_full <= (fifo_next >= FULL_THR);
      if (rdy) begin
        mem_din <= rd_next;
        rx_pop  <= io & ~req.wr & (off == IO_DATA) & rx_valid;
        if (push_req && fifo_full && !pop_req) tx_overflow <= 1'b1;
      end else begin
        rx_pop <= 1'b0;
      end
    end
  end

  // Gated by rst so a reset edge also suppresses the pending store.
  always_ff @(posedge clk) begin
    if (!rst && rdy && req.wr && !io) ram[ram_a] <= req.d;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: hand-computed vector table, directed corner
// sequences and a randomized run against a queue/array reference model.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst, rdy, mem_wr, tx_ready, rx_valid;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, rx_data;
  logic [7:0]  mem_din, tx_data;
  logic        io_buffer_full, tx_valid, rx_pop, tx_overflow;

  int checks = 0;
  int errors = 0;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] q_m [$];
  logic [7:0] din_m;
  bit         din_ok, rxp_m, ovf_m, full_m;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [7:0]  e_din;
    logic        e_pop;
    logic        e_full;
    logic        e_ovf;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_m.delete();
    ovf_m = 0; full_m = 0; rxp_m = 0; din_m = 8'h00; din_ok = 1;
  endtask

  // Apply one request for one edge, advance the model, compare all outputs.
  task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic r, input logic txr, input logic rxv, input logic [7:0] rxd);
    int  sz;
    bit  io;
    int  key;
    logic [2:0] off;
    mem_a = a; mem_wr = wr; mem_dout = d; rdy = r;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    sz  = q_m.size();
    io  = (a[17:16] == 2'b11);
    off = a[2:0];
    key = int'(a[16:0]);
    if (r) begin
      rxp_m  = io && !wr && off == 3'd0 && rxv;
      din_ok = 1;
      if (wr)                  din_m = 8'h00;
      else if (io) begin
        if (off == 3'd0)       din_m = rxv ? rxd : 8'h00;
        else if (off == 3'd4)  din_m = {6'b0, (sz == 0), rxv};
        else                   din_m = 8'h00;
      end else if (ram_m.exists(key)) din_m = ram_m[key];
      else                     din_ok = 0;
    end else begin
      rxp_m = 0;
    end
    if (sz > 0 && txr) void'(q_m.pop_front());
    if (r && io && wr && off == 3'd0) begin
      if (q_m.size() < 8) q_m.push_back(d);
      else ovf_m = 1;
    end
    if (r && wr && !io) ram_m[key] = d;
    full_m = (q_m.size() >= 6);
    @(posedge clk);
    #1;
    if (din_ok) chk("mem_din", mem_din, din_m);
    chk("rx_pop", rx_pop, rxp_m);
    chk("tx_valid", tx_valid, q_m.size() > 0);
    if (q_m.size() > 0) chk("tx_data", tx_data, q_m[0]);
    chk("io_buffer_full", io_buffer_full, full_m);
    chk("tx_overflow", tx_overflow, ovf_m);
  endtask

  // Asserts rst at the current time (between edges) and holds it over one edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_full", io_buffer_full, 1'b0);
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_rx_pop", rx_pop, 1'b0);
    chk("rst_overflow", tx_overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic wr, input logic [7:0] d,
                              input logic rxv, input logic [7:0] rxd, input logic txr,
                              input logic [7:0] e_din, input logic e_pop,
                              input logic e_full, input logic e_ovf);
    vec_t v;
    v = '{a, wr, d, rxv, rxd, txr, e_din, e_pop, e_full, e_ovf};
    return v;
  endfunction

  initial begin
    rst = 1'b0; rdy = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #3;
    do_reset();

    // Hand-computed vectors, applied in order from reset.
    tbl.push_back(mk(32'h00010, 1, 8'hAB, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(32'h00010, 0, 8'h00, 0, 8'h00, 0, 8'hAB, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(32'h00100 + i, 1, 8'(8'h11 * (i + 1)), 0, 8'h00, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(32'h00100 + i, 0, 8'h00, 0, 8'h00, 0, 8'(8'h11 * (i + 1)), 0, 0, 0));
    tbl.push_back(mk(32'h40010, 0, 8'h00, 0, 8'h00, 0, 8'hAB, 0, 0, 0));
    tbl.push_back(mk(32'h20010, 0, 8'h00, 0, 8'h00, 0, 8'hAB, 0, 0, 0));
    tbl.push_back(mk(32'h30000, 0, 8'h00, 1, 8'h5A, 0, 8'h5A, 1, 0, 0));
    tbl.push_back(mk(32'h30004, 0, 8'h00, 1, 8'h5A, 0, 8'h03, 0, 0, 0));
    tbl.push_back(mk(32'h30000, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(32'h30004, 1, 8'hFF, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(32'h30001, 1, 8'hEE, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(32'h30003, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(32'h30004, 0, 8'h00, 0, 8'h00, 0, 8'h02, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(32'h30000, 1, 8'(8'hA0 + i), 0, 8'h00, 0, 8'h00, 0, i >= 5, 0));
    tbl.push_back(mk(32'h30000, 1, 8'hA8, 0, 8'h00, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(32'h30004, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1));

    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].wr, tbl[i].d, 1'b1, tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
      chk($sformatf("vec%0d_din", i), mem_din, tbl[i].e_din);
      chk($sformatf("vec%0d_pop", i), rx_pop, tbl[i].e_pop);
      chk($sformatf("vec%0d_full", i), io_buffer_full, tbl[i].e_full);
      chk($sformatf("vec%0d_ovf", i), tx_overflow, tbl[i].e_ovf);
    end
    chk("head_after_drop", tx_data, 8'hA0);

    // Full FIFO with simultaneous pop and push: accepted, no overflow.
    do_reset();
    for (int i = 0; i < 8; i++) step(32'h30000, 1, 8'(8'hC0 + i), 1, 0, 0, 8'h00);
    step(32'h30000, 1, 8'hC8, 1, 1, 0, 8'h00);
    chk("pushpop_ovf", tx_overflow, 1'b0);
    chk("pushpop_head", tx_data, 8'hC1);
    chk("pushpop_full", io_buffer_full, 1'b1);
    for (int i = 0; i < 3; i++) step(32'h30004, 0, 8'h00, 1, 1, 0, 8'h00);
    chk("drain_full_drop", io_buffer_full, 1'b0);
    for (int i = 0; i < 6; i++) step(32'h30004, 0, 8'h00, 1, 1, 0, 8'h00);
    chk("drain_empty", tx_valid, 1'b0);

    // rdy low: no push/store/rx_pop, mem_din holds, sink still drains.
    step(32'h30000, 1, 8'hD0, 1, 0, 0, 8'h00);
    step(32'h30000, 1, 8'hD1, 1, 0, 0, 8'h00);
    step(32'h00010, 0, 8'h00, 1, 0, 0, 8'h00);
    step(32'h30000, 1, 8'hD2, 0, 1, 1, 8'h77);
    chk("rdy0_hold_din", mem_din, 8'hAB);
    chk("rdy0_rx_pop", rx_pop, 1'b0);
    chk("rdy0_drain_head", tx_data, 8'hD1);
    step(32'h00010, 1, 8'h55, 0, 0, 0, 8'h00);
    step(32'h00010, 0, 8'h00, 1, 1, 0, 8'h00);
    chk("rdy0_no_store", mem_din, 8'hAB);
    chk("rdy0_drained", tx_valid, 1'b0);

    // Reset mid-stream with a store pending on the reset edge.
    step(32'h00222, 1, 8'h77, 1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(32'h30000, 1, 8'(8'hE0 + i), 1, 0, 0, 8'h00);
    chk("pre_rst_full", io_buffer_full, 1'b1);
    mem_a = 32'h00222; mem_wr = 1'b1; mem_dout = 8'h99; rdy = 1'b1;
    do_reset();
    step(32'h00222, 0, 8'h00, 1, 0, 0, 8'h00);
    chk("post_rst_ram", mem_din, 8'h77);
    step(32'h00100, 0, 8'h00, 1, 0, 0, 8'h00);
    chk("post_rst_ram2", mem_din, 8'h11);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r, a;
      r = $urandom;
      a = $urandom;
      if (r % 3 == 0) begin
        a[17:16] = 2'b11;
        a[15:3]  = '0;
      end else begin
        a[16]    = 1'b0;
        a[15:4]  = r[4] ? 12'hFFF : 12'h000;
      end
      step(a, r[8], 8'($urandom), r[12:9] != 4'd0, r[13] & r[14] | r[15],
           r[16], 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
